// File: rtl/spi_pkg.sv
// Shared constants for the multi-chip-select SPI master.
package spi_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // SPI mode encoding, packed as {cpol, cpha}
    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;
    localparam logic [1:0] MODE_2 = 2'b10;
    localparam logic [1:0] MODE_3 = 2'b11;

    localparam int MODE_CPOL_BIT = 1;
    localparam int MODE_CPHA_BIT = 0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: while enabled, pulses tick on every CLK_DIV-th cycle.
// The count wraps on each tick, so consecutive half-periods are always whole.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("spi_clk_div: CLK_DIV must be in 1..255");
    end

    logic [CW-1:0] r_cnt;

    assign tick = enable && (r_cnt == CW'(CLK_DIV - 1));

    // Cycle counter within the current half-period
    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with per-transfer mode selection and NUM_CS active-low chip selects.
// Transfer timeline: SETUP (CLK_DIV) -> SHIFT (2*DATA_W half-periods) -> HOLD (CLK_DIV).
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DATA_W-1:0]             tx_data,
    // One spare code point beyond NUM_CS-1 so an out-of-range select is representable
    input  logic [$clog2(NUM_CS+1)-1:0]   cs_sel,
    input  logic                          cpol,
    input  logic                          cpha,
    output logic                          rx_valid,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          cs_err,
    output logic                          SCLK,
    output logic                          MOSI,
    input  logic                          MISO,
    output logic [NUM_CS-1:0]             CS_N
);

    localparam int EW = $clog2(2 * DATA_W);

    if (DATA_W < 4 || DATA_W > 32) begin : g_bad_data_w
        $error("spi_master_multi: DATA_W must be in 4..32");
    end
    if (NUM_CS < 1 || NUM_CS > 8) begin : g_bad_num_cs
        $error("spi_master_multi: NUM_CS must be in 1..8");
    end

    logic [1:0]        r_state;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic [EW-1:0]     r_edge;
    logic [NUM_CS-1:0] r_cs_n;
    logic              r_sclk;
    logic              r_rx_valid;
    logic              r_cs_err;

    logic              w_tick;
    logic              w_div_clear;
    logic              w_div_en;
    logic              w_sel_ok;
    logic              w_leading;
    logic              w_last;
    logic              w_sample;
    logic              w_advance;
    logic [DATA_W-1:0] w_rx_next;

    assign tx_ready = (r_state == ST_IDLE);
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign cs_err   = r_cs_err;
    assign SCLK     = r_sclk;
    assign MOSI     = r_tx[DATA_W-1];
    assign CS_N     = r_cs_n;

    // Counter is held at zero in IDLE, so every transfer starts on a fresh half-period
    assign w_div_clear = RESET || (r_state == ST_IDLE);
    assign w_div_en    = (r_state != ST_IDLE);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (CLOCK_50),
        .clear  (w_div_clear),
        .enable (w_div_en),
        .tick   (w_tick)
    );

    assign w_sel_ok  = (32'(cs_sel) < 32'(NUM_CS));
    assign w_leading = ~r_edge[0];
    assign w_last    = (r_edge == EW'(2 * DATA_W - 1));

    // Edge roles: MSB is already on MOSI from SETUP, so in cpha=1 the first
    // leading edge leaves it in place and later leading edges advance.
    always_comb begin
        w_sample  = 1'b0;
        w_advance = 1'b0;
        if (r_mode[MODE_CPHA_BIT] == 1'b0) begin
            w_sample  = w_leading;
            w_advance = ~w_leading;
        end else begin
            w_sample  = ~w_leading;
            w_advance = w_leading && (r_edge != '0);
        end
        w_rx_next = w_sample ? {r_rx[DATA_W-2:0], MISO} : r_rx;
    end

    // Transfer sequencing, shifting and output registers
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_edge     <= '0;
            r_cs_n     <= '1;
            r_sclk     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_cs_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_cs_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        if (w_sel_ok) begin
                            r_state <= ST_SETUP;
                            r_mode  <= {cpol, cpha};
                            r_tx    <= tx_data;
                            r_rx    <= '0;
                            r_edge  <= '0;
                            r_sclk  <= cpol;
                            r_cs_n  <= ~(NUM_CS'(1) << cs_sel);
                        end else begin
                            r_cs_err <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        r_edge <= r_edge + 1'b1;
                        r_rx   <= w_rx_next;
                        if (w_advance) begin
                            r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                        end
                        if (w_last) begin
                            r_state    <= ST_HOLD;
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                        r_cs_n  <= '1;
                        r_tx    <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi (DATA_W=8, NUM_CS=2, CLK_DIV=2).
module tb_spi_master_multi;

    localparam int DATA_W  = 8;
    localparam int NUM_CS  = 2;
    localparam int CLK_DIV = 2;

    logic              CLOCK_50 = 1'b0;
    logic              RESET;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic [1:0]        cs_sel;
    logic              cpol;
    logic              cpha;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              cs_err;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic [NUM_CS-1:0] CS_N;

    logic              loopback;
    logic              miso_tie;

    int                n_vec  = 0;
    int                n_miss = 0;
    logic [7:0]        exp_q[$];
    logic [7:0]        m_exp;

    assign MISO = loopback ? MOSI : miso_tie;

    always #5 CLOCK_50 = ~CLOCK_50;

    spi_master_multi #(
        .DATA_W  (DATA_W),
        .NUM_CS  (NUM_CS),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .cs_sel   (cs_sel),
        .cpol     (cpol),
        .cpha     (cpha),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .cs_err   (cs_err),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .CS_N     (CS_N)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rx_valid pulse must match the oldest outstanding expectation
    always @(negedge CLOCK_50) begin
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 32'd1, 32'd0);
            end else begin
                m_exp = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(m_exp));
            end
        end
    end

    // One complete transfer; with hold set, tx_valid stays high and the next
    // request's fields are presented right after acceptance.
    task automatic run_xfer(input logic [7:0] data, input logic [1:0] sel,
                            input logic pol, input logic pha, input logic [7:0] exp_rx,
                            input bit hold, input logic [7:0] nx_data, input logic [1:0] nx_sel,
                            input logic nx_pol, input logic nx_pha);
        int         n;
        int         edges;
        int         cs_bad;
        logic       prev;
        logic       first;
        logic [1:0] cs_exp;
        cs_exp = (sel == 2'd0) ? 2'b10 : 2'b01;
        n = 0;
        while (!tx_ready && n < 200) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        check("pre_ready", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = data;
        cs_sel   = sel;
        cpol     = pol;
        cpha     = pha;
        exp_q.push_back(exp_rx);
        @(posedge CLOCK_50); #1;
        if (hold) begin
            tx_data = nx_data;
            cs_sel  = nx_sel;
            cpol    = nx_pol;
            cpha    = nx_pha;
        end else begin
            tx_valid = 1'b0;
            tx_data  = ~data;
            cs_sel   = sel ^ 2'b01;
            cpol     = ~pol;
            cpha     = ~pha;
        end
        n      = 1;
        edges  = 0;
        cs_bad = 0;
        first  = SCLK;
        prev   = SCLK;
        while (!tx_ready && n < 200) begin
            if (CS_N !== cs_exp) cs_bad++;
            if (SCLK !== prev) edges++;
            prev = SCLK;
            @(posedge CLOCK_50); #1;
            n++;
        end
        if (SCLK !== prev) edges++;
        check("ready_latency", 32'(n), 32'd37);
        check("cs_active", 32'(cs_bad), 32'd0);
        check("sclk_setup", 32'(first), 32'(pol));
        check("sclk_edges", 32'(edges), 32'd16);
        check("sclk_idle", 32'(SCLK), 32'(pol));
        check("cs_idle", 32'(CS_N), 32'h3);
        check("mosi_idle", 32'(MOSI), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_sclk;
        RESET    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        cs_sel   = '0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        loopback = 1'b1;
        miso_tie = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_cs_n", 32'(CS_N), 32'h3);
        check("rst_sclk", 32'(SCLK), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_cs_err", 32'(cs_err), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);

        // Mode 0 loopback to CS0
        loopback = 1'b1;
        run_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        // Mode 3, MISO tied high, CS1
        loopback = 1'b0;
        miso_tie = 1'b1;
        run_xfer(8'h12, 2'd1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        // Mode 1 and mode 2 loopback
        loopback = 1'b1;
        run_xfer(8'h5A, 2'd0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        run_xfer(8'h96, 2'd1, 1'b1, 1'b0, 8'h96, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

        // Out-of-range chip select
        prev_sclk = SCLK;
        tx_valid  = 1'b1;
        tx_data   = 8'h77;
        cs_sel    = 2'd2;
        cpol      = ~prev_sclk;
        cpha      = 1'b0;
        @(posedge CLOCK_50); #1;
        tx_valid = 1'b0;
        check("cs_err_pulse", 32'(cs_err), 32'd1);
        check("cs_err_ready", 32'(tx_ready), 32'd1);
        check("cs_err_cs_n", 32'(CS_N), 32'h3);
        check("cs_err_sclk", 32'(SCLK), 32'(prev_sclk));
        @(posedge CLOCK_50); #1;
        check("cs_err_single", 32'(cs_err), 32'd0);
        check("cs_err_sclk2", 32'(SCLK), 32'(prev_sclk));
        check("cs_err_cs_n2", 32'(CS_N), 32'h3);

        // Reset in the 10th SHIFT cycle; no expectation is queued
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        cs_sel   = 2'd0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        @(posedge CLOCK_50); #1;
        tx_valid = 1'b0;
        for (int k = 1; k < 12; k++) begin
            @(posedge CLOCK_50); #1;
        end
        check("mid_busy", 32'(tx_ready), 32'd0);
        check("mid_cs_n", 32'(CS_N), 32'h2);
        RESET = 1'b1;
        @(posedge CLOCK_50); #1;
        RESET = 1'b0;
        check("mid_rst_cs_n", 32'(CS_N), 32'h3);
        check("mid_rst_sclk", 32'(SCLK), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_mosi", 32'(MOSI), 32'd0);
        check("mid_rst_rx_data", 32'(rx_data), 32'd0);
        repeat (45) @(posedge CLOCK_50);
        #1;

        // Back-to-back with tx_valid held high
        loopback = 1'b1;
        run_xfer(8'h3C, 2'd0, 1'b0, 1'b0, 8'h3C, 1'b1, 8'hC3, 2'd1, 1'b0, 1'b0);
        run_xfer(8'hC3, 2'd1, 1'b0, 1'b0, 8'hC3, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

        repeat (5) @(posedge CLOCK_50);
        #1;
        check("rx_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
